uart_cmd_parser: RTL and testbench

//  Consumes the byte stream produced by the UART receive stage and assembles framed

---
 rtl/corr_uart_pkg.sv | 21 ++
 rtl/uart_gap_timer.sv | 31 +++
 rtl/uart_cmd_parser.sv | 124 ++++++++++++
 tb/tb_uart_cmd_parser.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/corr_uart_pkg.sv
// Shared types and constants for the correlator UART command path.
// Latency: n/a (declarations only). Backpressure: n/a.
package corr_uart_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_DATA = 2'd2,
      ST_CHK  = 2'd3
   } state_t;

   localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

   // SYNC + ADDR + CHK around the data payload
   localparam int FRAME_OVERHEAD = 3;

   function automatic int frame_len(input int data_bytes);
      return data_bytes + FRAME_OVERHEAD;
   endfunction

endpackage

// File: rtl/uart_gap_timer.sv
// Inter-byte gap timer: counts while enabled, flags expiry at TIMEOUT-1.
// Latency: expire is combinational from the count. Backpressure: none.
module uart_gap_timer #(
   parameter int TIMEOUT = 1024
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic en,
   output logic expire
);

   localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);

   logic [TW-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (en && cnt != LAST) begin
         cnt <= cnt + TW'(1);
      end
   end

   // clear has priority so a byte landing on the expiry cycle always wins
   assign expire = en && !clear && (cnt == LAST);

endmodule

// File: rtl/uart_cmd_parser.sv
// Assembles SYNC/ADDR/DATA/CHK byte frames into register writes; errors on bad chk or gap.
// Latency: wr_en/cmd_err one cycle after the CHK byte strobe. Backpressure: none, one byte per cycle.
module uart_cmd_parser
   import corr_uart_pkg::*;
#(
   parameter int         DATA_BYTES = 4,
   parameter logic [7:0] SYNC_BYTE  = DEFAULT_SYNC_BYTE,
   parameter int         TIMEOUT    = 1024
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [7:0]              din,
   input  logic                    din_valid,
   output logic                    wr_en,
   output logic [7:0]              wr_addr,
   output logic [8*DATA_BYTES-1:0] wr_data,
   output logic                    cmd_err,
   output logic                    busy
);

   localparam int DW = 8 * DATA_BYTES;
   localparam int CW = $clog2(DATA_BYTES) + 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(DATA_BYTES - 1);

   state_t          state, state_nxt;
   logic [7:0]      addr_sh, addr_sh_nxt;
   logic [DW-1:0]   data_sh, data_sh_nxt;
   logic [7:0]      chk, chk_nxt;
   logic [CW-1:0]   byte_cnt, byte_cnt_nxt;
   logic [7:0]      wr_addr_nxt;
   logic [DW-1:0]   wr_data_nxt;
   logic            wr_en_nxt, cmd_err_nxt;
   logic            gap_expire;

   uart_gap_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_gap_timer (
      .clk    (clk),
      .rst    (rst),
      .clear  (state == ST_IDLE || din_valid),
      .en     (state != ST_IDLE),
      .expire (gap_expire)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_IDLE;
         addr_sh  <= '0;
         data_sh  <= '0;
         chk      <= '0;
         byte_cnt <= '0;
         wr_addr  <= '0;
         wr_data  <= '0;
         wr_en    <= 1'b0;
         cmd_err  <= 1'b0;
      end else begin
         state    <= state_nxt;
         addr_sh  <= addr_sh_nxt;
         data_sh  <= data_sh_nxt;
         chk      <= chk_nxt;
         byte_cnt <= byte_cnt_nxt;
         wr_addr  <= wr_addr_nxt;
         wr_data  <= wr_data_nxt;
         wr_en    <= wr_en_nxt;
         cmd_err  <= cmd_err_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      addr_sh_nxt  = addr_sh;
      data_sh_nxt  = data_sh;
      chk_nxt      = chk;
      byte_cnt_nxt = byte_cnt;
      wr_addr_nxt  = wr_addr;
      wr_data_nxt  = wr_data;
      wr_en_nxt    = 1'b0;
      cmd_err_nxt  = 1'b0;

      unique case (state)
         ST_IDLE: begin
            if (din_valid && din == SYNC_BYTE) state_nxt = ST_ADDR;
         end
         ST_ADDR: begin
            if (din_valid) begin
               addr_sh_nxt  = din;
               chk_nxt      = din;
               byte_cnt_nxt = '0;
               state_nxt    = ST_DATA;
            end
         end
         ST_DATA: begin
            if (din_valid) begin
               data_sh_nxt  = (data_sh << 8) | DW'(din);
               chk_nxt      = chk ^ din;
               byte_cnt_nxt = byte_cnt + CW'(1);
               if (byte_cnt == LAST_CNT) state_nxt = ST_CHK;
            end
         end
         ST_CHK: begin
            if (din_valid) begin
               if (din == chk) begin
                  wr_en_nxt   = 1'b1;
                  wr_addr_nxt = addr_sh;
                  wr_data_nxt = data_sh;
               end else begin
                  cmd_err_nxt = 1'b1;
               end
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase

      // expiry is already masked by din_valid inside the timer
      if (gap_expire) begin
         cmd_err_nxt = 1'b1;
         state_nxt   = ST_IDLE;
      end
   end

   assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Self-checking bench for uart_cmd_parser against a frame-level reference model.
module tb_uart_cmd_parser;

   localparam int         DB   = 4;
   localparam int         TO   = 16;
   localparam logic [7:0] SYNC = 8'hA5;
   localparam int         OW   = 3 + 8 + 8 * DB;

   logic            clk = 1'b0;
   logic            rst;
   logic [7:0]      din;
   logic            din_valid;
   logic            wr_en;
   logic [7:0]      wr_addr;
   logic [8*DB-1:0] wr_data;
   logic            cmd_err;
   logic            busy;

   uart_cmd_parser #(
      .DATA_BYTES (DB),
      .SYNC_BYTE  (SYNC),
      .TIMEOUT    (TO)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .din       (din),
      .din_valid (din_valid),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .cmd_err   (cmd_err),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;

   // reference model: a frame is collected as a list of bytes and judged once complete
   logic [7:0]      frame_q[$];
   bit              in_frame = 0;
   longint          now_t    = 0;
   longint          last_t   = 0;
   logic            exp_wr   = 0;
   logic            exp_err  = 0;
   logic [7:0]      exp_addr = 0;
   logic [8*DB-1:0] exp_data = 0;
   int              wr_pulses  = 0;
   int              err_pulses = 0;

   task automatic model_edge(input bit vld, input logic [7:0] b);
      logic [7:0] x;
      exp_wr  = 0;
      exp_err = 0;
      if (vld) begin
         if (!in_frame) begin
            if (b == SYNC) begin
               in_frame = 1;
               frame_q.delete();
            end
         end else begin
            frame_q.push_back(b);
            if (frame_q.size() == DB + 2) begin
               x = 8'h00;
               for (int i = 0; i < DB + 1; i++) x ^= frame_q[i];
               if (x == b) begin
                  exp_wr   = 1;
                  exp_addr = frame_q[0];
                  exp_data = '0;
                  for (int i = 1; i <= DB; i++) exp_data = (exp_data << 8) | (8*DB)'(frame_q[i]);
               end else begin
                  exp_err = 1;
               end
               in_frame = 0;
            end
         end
         last_t = now_t;
      end else if (in_frame && (now_t - last_t) == TO) begin
         exp_err  = 1;
         in_frame = 0;
      end
   endtask

   function automatic logic [OW-1:0] obs();
      return {wr_en, cmd_err, busy, wr_addr, wr_data};
   endfunction

   function automatic logic [OW-1:0] expv();
      return {exp_wr, exp_err, in_frame, exp_addr, exp_data};
   endfunction

   task automatic step(input bit vld, input logic [7:0] b);
      @(negedge clk);
      din_valid = vld;
      din       = vld ? b : 8'($urandom);
      @(posedge clk);
      now_t++;
      model_edge(vld, b);
      #1;
      if (wr_en)   wr_pulses++;
      if (cmd_err) err_pulses++;
   endtask

   function automatic logic [7:0] xor_of(input logic [7:0] a, input logic [8*DB-1:0] d);
      logic [7:0] x = a;
      for (int i = 0; i < DB; i++) x ^= d[8*i +: 8];
      return x;
   endfunction

   task automatic test_reset();
      rst = 1; din_valid = 0; din = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      vectors++;
      if ({wr_en, cmd_err, busy, wr_addr, wr_data} !== '0) begin
         miscompares++;
         $display("FAIL reset_state got=%h want=0", obs());
      end
      @(negedge clk);
      rst = 0;
   endtask

   task automatic test_good_frame();
      logic [7:0] bytes [6];
      bytes = '{8'hA5, 8'h10, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
      wr_pulses = 0;
      foreach (bytes[i]) begin
         step(1, bytes[i]);
         vectors++;
         if (obs() !== expv()) begin miscompares++; $display("FAIL good_frame got=%h want=%h", obs(), expv()); end
      end
      // checksum of 10,DE,AD,BE,EF is 8'h32
      step(1, 8'h32);
      vectors++;
      if (wr_en !== 1'b1 || cmd_err !== 1'b0 || wr_addr !== 8'h10 || wr_data !== 32'hDEADBEEF) begin
         miscompares++;
         $display("FAIL good_frame_write got wr=%b err=%b a=%h d=%h want wr=1 err=0 a=10 d=deadbeef",
                  wr_en, cmd_err, wr_addr, wr_data);
      end
      step(0, 8'h00);
      vectors++;
      if (obs() !== expv() || wr_pulses != 1) begin
         miscompares++;
         $display("FAIL good_frame_single got=%h want=%h pulses=%0d", obs(), expv(), wr_pulses);
      end
   endtask

   task automatic test_bad_chk();
      logic [7:0] bad [2];
      bad = '{8'h00, 8'h8F};
      foreach (bad[k]) begin
         err_pulses = 0; wr_pulses = 0;
         step(1, 8'hA5); step(1, 8'h10);
         step(1, 8'h12); step(1, 8'h34); step(1, 8'h56); step(1, 8'h78);
         step(1, bad[k]);
         vectors++;
         if (obs() !== expv()) begin miscompares++; $display("FAIL bad_chk got=%h want=%h", obs(), expv()); end
         step(0, 8'h00);
         vectors++;
         if (err_pulses != 1 || wr_pulses != 0 || wr_addr !== 8'h10 || wr_data !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL bad_chk_hold errs=%0d wrs=%0d a=%h d=%h want 1 0 10 deadbeef",
                     err_pulses, wr_pulses, wr_addr, wr_data);
         end
      end
   endtask

   task automatic test_timeout();
      logic [8*DB-1:0] d;
      err_pulses = 0;
      step(1, 8'hA5); step(1, 8'h10); step(1, 8'hDE);
      for (int i = 0; i < TO; i++) begin
         step(0, 8'h00);
         vectors++;
         if (obs() !== expv()) begin miscompares++; $display("FAIL timeout got=%h want=%h cyc=%0d", obs(), expv(), i); end
      end
      vectors++;
      if (err_pulses != 1 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL timeout_err errs=%0d busy=%b want 1 0", err_pulses, busy);
      end
      d = {$urandom};
      step(1, 8'hA5); step(1, 8'h42);
      for (int i = DB - 1; i >= 0; i--) step(1, d[8*i +: 8]);
      step(1, xor_of(8'h42, d));
      vectors++;
      if (wr_en !== 1'b1 || wr_addr !== 8'h42 || wr_data !== d) begin
         miscompares++;
         $display("FAIL timeout_recover wr=%b a=%h d=%h want 1 42 %h", wr_en, wr_addr, wr_data, d);
      end
   endtask

   task automatic test_back_to_back();
      logic [8*DB-1:0] d;
      step(1, 8'h00); step(1, 8'hFF); step(1, 8'hA5); step(1, 8'hA5);
      d = 32'h0102A503;
      for (int i = DB - 1; i >= 0; i--) step(1, d[8*i +: 8]);
      step(1, xor_of(8'hA5, d));
      vectors++;
      if (wr_en !== 1'b1 || wr_addr !== 8'hA5 || wr_data !== d) begin
         miscompares++;
         $display("FAIL lead_garbage wr=%b a=%h d=%h want 1 a5 %h", wr_en, wr_addr, wr_data, d);
      end
      wr_pulses = 0;
      for (int f = 0; f < 2; f++) begin
         logic [7:0] a;
         a = 8'($urandom);
         d = {$urandom};
         step(1, 8'hA5); step(1, a);
         for (int i = DB - 1; i >= 0; i--) step(1, d[8*i +: 8]);
         step(1, xor_of(a, d));
         vectors++;
         if (obs() !== expv() || wr_addr !== a || wr_data !== d) begin
            miscompares++;
            $display("FAIL back_to_back f=%0d got=%h want=%h", f, obs(), expv());
         end
      end
      vectors++;
      if (wr_pulses != 2) begin miscompares++; $display("FAIL back_to_back_count got=%0d want=2", wr_pulses); end
   endtask

   task automatic test_reset_mid_frame();
      logic [8*DB-1:0] d;
      step(1, 8'hA5); step(1, 8'h33); step(1, 8'h01); step(1, 8'h02); step(1, 8'h03);
      @(negedge clk);
      din_valid = 0;
      rst = 1;
      #1;
      vectors++;
      if ({wr_en, cmd_err, busy, wr_addr, wr_data} !== '0) begin
         miscompares++;
         $display("FAIL reset_mid_frame got=%h want=0", obs());
      end
      in_frame = 0; exp_addr = '0; exp_data = '0; exp_wr = 0; exp_err = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 0;
      wr_pulses = 0;
      d = {$urandom};
      step(1, 8'hA5); step(1, 8'h5A);
      for (int i = DB - 1; i >= 0; i--) step(1, d[8*i +: 8]);
      step(1, xor_of(8'h5A, d));
      step(0, 8'h00);
      vectors++;
      if (wr_pulses != 1 || wr_addr !== 8'h5A || wr_data !== d || obs() !== expv()) begin
         miscompares++;
         $display("FAIL reset_recover pulses=%0d a=%h d=%h want 1 5a %h", wr_pulses, wr_addr, wr_data, d);
      end
   endtask

   task automatic test_expiry_edge();
      logic [8*DB-1:0] d;
      err_pulses = 0;
      d = {$urandom};
      step(1, 8'hA5); step(1, 8'h77);
      for (int i = DB - 1; i >= 0; i--) step(1, d[8*i +: 8]);
      repeat (TO - 1) step(0, 8'h00);
      step(1, xor_of(8'h77, d));
      vectors++;
      if (wr_en !== 1'b1 || cmd_err !== 1'b0 || err_pulses != 0 || wr_addr !== 8'h77 || wr_data !== d) begin
         miscompares++;
         $display("FAIL expiry_edge wr=%b err=%b errs=%0d a=%h want 1 0 0 77", wr_en, cmd_err, err_pulses, wr_addr);
      end
   endtask

   task automatic test_random();
      for (int f = 0; f < 120; f++) begin
         logic [7:0]      a, c;
         logic [8*DB-1:0] d;
         logic [7:0]      fb [DB+2];
         a = 8'($urandom);
         d = {$urandom};
         c = ($urandom_range(0, 3) != 0) ? xor_of(a, d) : 8'($urandom);
         fb[0] = a;
         for (int i = 0; i < DB; i++) fb[1+i] = d[8*(DB-1-i) +: 8];
         fb[DB+1] = c;
         if ($urandom_range(0, 3) == 0) begin
            step(1, 8'($urandom));
            vectors++;
            if (obs() !== expv()) begin miscompares++; $display("FAIL random_garbage got=%h want=%h", obs(), expv()); end
         end
         step(1, SYNC);
         foreach (fb[i]) begin
            int gap;
            gap = ($urandom_range(0, 7) == 0) ? int'($urandom_range(TO - 2, TO + 1)) : int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) begin
               step(0, 8'h00);
               vectors++;
               if (obs() !== expv()) begin miscompares++; $display("FAIL random_gap got=%h want=%h", obs(), expv()); end
            end
            step(1, fb[i]);
            vectors++;
            if (obs() !== expv()) begin miscompares++; $display("FAIL random_byte got=%h want=%h", obs(), expv()); end
         end
      end
      repeat (TO + 2) begin
         step(0, 8'h00);
         vectors++;
         if (obs() !== expv()) begin miscompares++; $display("FAIL random_drain got=%h want=%h", obs(), expv()); end
      end
   endtask

   initial begin
      test_reset();
      test_good_frame();
      test_bad_chk();
      test_timeout();
      test_back_to_back();
      test_reset_mid_frame();
      test_expiry_edge();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
